// File: rtl/pio_sda_in_9557_if.sv
// rtl/pio_sda_in_9557_if.sv - Avalon-MM register bus bundle for the SDA read-back PIO
interface pio_sda_in_9557_if #(
  parameter int WIDTH = 1
);
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/pio_sda_in_9557.sv
// rtl/pio_sda_in_9557.sv - SDA input PIO with sync, edge capture, irq; optional filter via PIO_SDA_IN_GLITCH_FILTER_EN
module pio_sda_in_9557 #(
  parameter int       WIDTH         = 1,
  parameter int       EDGE_TYPE     = 1,
  parameter logic     RESET_LEVEL   = 1'b1,
  parameter int       FILTER_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  pio_sda_in_9557_if.slave    bus,
  input  logic [WIDTH-1:0]    in_port,
  output logic                irq
);

  localparam logic [WIDTH-1:0] RESET_VEC = {WIDTH{RESET_LEVEL}};

  // Reject configurations the counters and register map cannot represent.
  if (WIDTH < 1 || WIDTH > 32 || FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_param_check
    $error("pio_sda_in_9557: WIDTH or FILTER_CYCLES out of range");
  end

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] capture_clear;
  logic             wr_en;

  // Two-flop synchroniser; resets to the idle line level so release is edge-free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= RESET_VEC;
      sync2 <= RESET_VEC;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef PIO_SDA_IN_GLITCH_FILTER_EN
  localparam logic [7:0] FILTER_LAST = 8'(FILTER_CYCLES - 1);

  logic [WIDTH-1:0][7:0] filt_cnt;
  logic [WIDTH-1:0]      filtered;

  // Per-bit stability counter: a new level is accepted only after it persists FILTER_CYCLES clocks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_cnt <= '0;
      filtered <= RESET_VEC;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] != filtered[i]) begin
          if (filt_cnt[i] == FILTER_LAST) begin
            filtered[i] <= sync2[i];
            filt_cnt[i] <= 8'd0;
          end else begin
            filt_cnt[i] <= filt_cnt[i] + 8'd1;
          end
        end else begin
          filt_cnt[i] <= 8'd0;
        end
      end
    end
  end

  assign data_in = filtered;
`else
  assign data_in = sync2;
`endif

  // Edge qualification against the previous data_in sample.
  always_comb begin
    edge_hit = '0;
    case (EDGE_TYPE)
      0:       edge_hit = data_in & ~prev;
      1:       edge_hit = ~data_in & prev;
      default: edge_hit = data_in ^ prev;
    endcase
  end

  assign wr_en         = bus.chipselect & ~bus.write_n;
  assign capture_clear = (wr_en && bus.address == 2'd3) ? bus.writedata : '0;

  // Edge history, sticky capture (a new edge beats a same-cycle clear) and mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev         <= RESET_VEC;
      edge_capture <= '0;
      irq_mask     <= '0;
    end else begin
      prev         <= data_in;
      edge_capture <= (edge_capture & ~capture_clear) | edge_hit;
      if (wr_en && bus.address == 2'd2) begin
        irq_mask <= bus.writedata;
      end
    end
  end

  // Zero-wait-state read mux; bus is driven to zero whenever the slave is not selected.
  always_comb begin
    bus.readdata = '0;
    if (bus.chipselect) begin
      case (bus.address)
        2'd0:    bus.readdata = data_in;
        2'd1:    bus.readdata = '0;
        2'd2:    bus.readdata = irq_mask;
        default: bus.readdata = edge_capture;
      endcase
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_pio_sda_in_9557.sv
// tb/tb_pio_sda_in_9557.sv - scoreboard bench for pio_sda_in_9557 against a pin-history reference model
module tb_pio_sda_in_9557;
  localparam int   WIDTH         = 4;
  localparam int   EDGE_TYPE     = 1;
  localparam logic RESET_LEVEL   = 1'b1;
  localparam int   FILTER_CYCLES = 4;
  localparam logic [WIDTH-1:0] RL_VEC = {WIDTH{RESET_LEVEL}};

  logic             clk = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] in_port;
  logic             irq;

  pio_sda_in_9557_if #(.WIDTH(WIDTH)) bus ();

  pio_sda_in_9557 #(
    .WIDTH        (WIDTH),
    .EDGE_TYPE    (EDGE_TYPE),
    .RESET_LEVEL  (RESET_LEVEL),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave),
    .in_port(in_port),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] rd;
    logic             irq;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: data_in is the pin value from two cycles earlier (or the filtered version of it).
  logic [WIDTH-1:0] pin_hist[$];
  logic [WIDTH-1:0] m_cap, m_mask, m_dprev, m_filt;
  int               m_run[WIDTH];

  task automatic model_clear();
    pin_hist.delete();
    m_cap   = '0;
    m_mask  = '0;
    m_dprev = RL_VEC;
    m_filt  = RL_VEC;
    for (int b = 0; b < WIDTH; b++) m_run[b] = 0;
  endtask

  // One bus cycle: drive inputs, push expected outputs, advance the model, wait for the edge.
  task automatic step(input logic [WIDTH-1:0] pin, input logic cs, input logic wn,
                      input logic [1:0] addr, input logic [WIDTH-1:0] wd);
    logic [WIDTH-1:0] s, d, rd, ev;
    exp_t e;
    int   k;
    in_port        = pin;
    bus.chipselect = cs;
    bus.write_n    = wn;
    bus.address    = addr;
    bus.writedata  = wd;
    pin_hist.push_back(pin);
    k = pin_hist.size() - 1;
    s = (k >= 2) ? pin_hist[k-2] : RL_VEC;
`ifdef PIO_SDA_IN_GLITCH_FILTER_EN
    d = m_filt;
`else
    d = s;
`endif
    rd = '0;
    if (cs) begin
      if (addr == 2'd0) rd = d;
      else if (addr == 2'd2) rd = m_mask;
      else if (addr == 2'd3) rd = m_cap;
    end
    e.rd  = rd;
    e.irq = |(m_cap & m_mask);
    exp_q.push_back(e);
    if (EDGE_TYPE == 0)      ev = d & ~m_dprev;
    else if (EDGE_TYPE == 1) ev = ~d & m_dprev;
    else                     ev = d ^ m_dprev;
    if (cs && !wn && addr == 2'd3) m_cap = m_cap & ~wd;
    m_cap = m_cap | ev;
    if (cs && !wn && addr == 2'd2) m_mask = wd;
    m_dprev = d;
`ifdef PIO_SDA_IN_GLITCH_FILTER_EN
    for (int b = 0; b < WIDTH; b++) begin
      if (s[b] != m_filt[b]) begin
        m_run[b]++;
        if (m_run[b] == FILTER_CYCLES) begin
          m_filt[b] = s[b];
          m_run[b]  = 0;
        end
      end else begin
        m_run[b] = 0;
      end
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic rd_step(input logic [WIDTH-1:0] pin, input logic [1:0] addr);
    step(pin, 1'b1, 1'b1, addr, '0);
  endtask

  task automatic wr_step(input logic [WIDTH-1:0] pin, input logic [1:0] addr, input logic [WIDTH-1:0] wd);
    step(pin, 1'b1, 1'b0, addr, wd);
  endtask

  // Hold reset for several cycles reading addr0 (must show the reset level, irq low), then release.
  task automatic do_reset(input bit toggle, input logic [WIDTH-1:0] release_pin);
    exp_t e;
    reset_n        = 1'b0;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    bus.address    = 2'd0;
    bus.writedata  = '0;
    for (int i = 0; i < 6; i++) begin
      in_port = toggle ? WIDTH'($urandom) : RL_VEC;
      e.rd    = RL_VEC;
      e.irq   = 1'b0;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
    end
    in_port = release_pin;
    reset_n = 1'b1;
    model_clear();
  endtask

  // Monitor: compare whatever the DUT presents against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.readdata !== e.rd) begin
          errors++;
          $display("FAIL readdata addr=%0d cs=%0b got %h expected %h at %0t",
                   bus.address, bus.chipselect, bus.readdata, e.rd, $time);
        end
        checks++;
        if (irq !== e.irq) begin
          errors++;
          $display("FAIL irq got %b expected %b at %0t", irq, e.irq, $time);
        end
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] pin;
    logic [1:0]       a;
    reset_n        = 1'b0;
    in_port        = RL_VEC;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 2'd0;
    bus.writedata  = '0;
    @(posedge clk);
    #1;

    // Idle after reset with the pin at its resting level.
    do_reset(1'b0, RL_VEC);
    for (int i = 0; i < 20; i++) step(RL_VEC, 1'b0, 1'b1, 2'd0, '0);
    rd_step(RL_VEC, 2'd0);
    rd_step(RL_VEC, 2'd3);
    rd_step(RL_VEC, 2'd1);

    // Falling edge on bit 0 with mask enabled, then W1C.
    wr_step(RL_VEC, 2'd2, '1);
    for (int i = 0; i < 5; i++) rd_step(4'hE, (i % 2 == 0) ? 2'd0 : 2'd3);
    wr_step(4'hE, 2'd3, 4'h1);
    rd_step(4'hE, 2'd3);
    rd_step(4'hE, 2'd3);

    // Writing 0 to a set capture bit leaves it set.
    for (int i = 0; i < 4; i++) rd_step(4'hC, 2'd3);
    wr_step(4'hC, 2'd3, 4'h0);
    rd_step(4'hC, 2'd3);

    // Falling edge on bit 2 coinciding with its W1C: set wins.
    step(4'h8, 1'b0, 1'b1, 2'd0, '0);
    step(4'h8, 1'b0, 1'b1, 2'd0, '0);
    wr_step(4'h8, 2'd3, 4'h4);
    rd_step(4'h8, 2'd3);

    // Mask off hides captures; mask on re-raises irq; reserved reads zero; writes to ro regs ignored.
    wr_step(4'h8, 2'd2, 4'h0);
    rd_step(4'h8, 2'd3);
    wr_step(4'h8, 2'd0, 4'h7);
    wr_step(4'h8, 2'd1, 4'hF);
    rd_step(4'h8, 2'd1);
    wr_step(4'h8, 2'd2, 4'h2);
    rd_step(4'h8, 2'd2);

    // Three falling edges on bit 3 before a single clear.
    wr_step(4'h8, 2'd3, '1);
    for (int r = 0; r < 3; r++) begin
      rd_step(4'h8, 2'd0);
      rd_step(4'h8, 2'd0);
      rd_step(4'h0, 2'd0);
      rd_step(4'h0, 2'd3);
    end
    for (int i = 0; i < 3; i++) rd_step(4'h0, 2'd3);
    wr_step(4'h0, 2'd3, 4'h8);
    rd_step(4'h0, 2'd3);

    // Short and long low pulses on bit 0 (filter rejects the short one when enabled).
    wr_step(RL_VEC, 2'd3, '1);
    wr_step(RL_VEC, 2'd2, '1);
    for (int i = 0; i < 10; i++) rd_step(RL_VEC, 2'd3);
    wr_step(RL_VEC, 2'd3, '1);
    for (int i = 0; i < 3; i++) rd_step(4'hE, 2'd0);
    for (int i = 0; i < 10; i++) rd_step(RL_VEC, (i % 2 == 0) ? 2'd0 : 2'd3);
    wr_step(RL_VEC, 2'd3, '1);
    for (int i = 0; i < 6; i++) rd_step(4'hE, 2'd0);
    for (int i = 0; i < 10; i++) rd_step(RL_VEC, (i % 2 == 0) ? 2'd0 : 2'd3);

    // Reset with the pin toggling, release with a random level, then random traffic.
    for (int r = 0; r < 2; r++) begin
      pin = WIDTH'($urandom);
      do_reset(1'b1, pin);
      for (int i = 0; i < 250; i++) begin
        if ($urandom_range(0, 5) == 0) pin[$urandom_range(0, WIDTH-1)] ^= 1'b1;
        a = 2'($urandom);
        step(pin, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), a, WIDTH'($urandom));
      end
    end

    step(pin, 1'b0, 1'b1, 2'd0, '0);
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
